exhaustive_stim_sequencer: RTL and testbench

Hardware controller that sequences a combinational DUT through every input vector in order, 0 to 2^IN_W−1, and compacts the DUT outputs into a multiple-input signature register (MISR). It drives the DUT input bus directly and sits between a host start/done handshake and the DUT under test. It is the synthesizable counterpart of the team's exhaustive directed-stimulus benches, for on-chip or emulation self-test.

---
 rtl/exhaustive_stim_sequencer_pkg.sv | 21 ++
 rtl/exhaustive_stim_sequencer_if.sv | 35 +++
 rtl/exhaustive_stim_sequencer_sig_misr.sv | 38 +++
 rtl/exhaustive_stim_sequencer.sv | 123 ++++++++++++
 tb/tb_exhaustive_stim_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/exhaustive_stim_sequencer_pkg.sv
// Shared definitions for the exhaustive stimulus sequencer.
//   seq_state_e    : sequencer FSM states
//   MISR_POLY      : signature feedback polynomial (low SIG_W bits used; 16'h1021 at SIG_W=16)
//   SETTLE_CYC_MIN : smallest legal settle time
//   SETTLE_CYC_MAX : largest legal settle time
//   SETTLE_CNT_W   : settle counter width, wide enough for SETTLE_CYC_MAX
package exhaustive_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } seq_state_e;

  localparam logic [63:0]  MISR_POLY      = 64'h1021;
  localparam int unsigned  SETTLE_CYC_MIN = 1;
  localparam int unsigned  SETTLE_CYC_MAX = 255;
  localparam int unsigned  SETTLE_CNT_W   = $clog2(SETTLE_CYC_MAX + 1);

endpackage

// File: rtl/exhaustive_stim_sequencer_if.sv
// Host/DUT-facing bus of the exhaustive stimulus sequencer.
//   start, abort : host run control
//   stim         : vector driven to the DUT under test
//   dut_out      : DUT response
//   busy, done   : run status
//   signature    : MISR result
//   golden, pass : signature compare, present only when SIG_COMPARE_EN is defined
// Modports: master = host + DUT side, slave = sequencer.
interface exhaustive_stim_sequencer_if #(
  parameter int unsigned IN_W  = 6,
  parameter int unsigned OUT_W = 3,
  parameter int unsigned SIG_W = 16
);
  logic             start;
  logic             abort;
  logic [IN_W-1:0]  stim;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;
`ifdef SIG_COMPARE_EN
  logic [SIG_W-1:0] golden;
  logic             pass;

  modport master (output start, abort, dut_out, golden,
                  input  stim, busy, done, signature, pass);
  modport slave  (input  start, abort, dut_out, golden,
                  output stim, busy, done, signature, pass);
`else
  modport master (output start, abort, dut_out,
                  input  stim, busy, done, signature);
  modport slave  (input  start, abort, dut_out,
                  output stim, busy, done, signature);
`endif
endinterface

// File: rtl/exhaustive_stim_sequencer_sig_misr.sv
// Multiple-input signature register.
//   clk, rst   : clock, asynchronous active-high reset
//   i_clear    : zero the signature (wins over i_enable)
//   i_enable   : fold i_data into the signature
//   i_data     : word to compact, zero-extended to SIG_W
//   o_sig      : registered signature
//   o_sig_next : value the signature takes on the next enabled edge
module sig_misr
  import exhaustive_seq_pkg::*;
#(
  parameter int unsigned      SIG_W  = 16,
  parameter int unsigned      DATA_W = 3,
  parameter logic [SIG_W-1:0] POLY   = MISR_POLY[SIG_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_data,
  output logic [SIG_W-1:0]  o_sig,
  output logic [SIG_W-1:0]  o_sig_next
);
  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_feedback;
  logic [SIG_W-1:0] w_sig_next;

  assign w_feedback = r_sig[SIG_W-1] ? POLY : '0;
  assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0} ^ w_feedback ^ SIG_W'(i_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_sig <= '0;
    else if (i_clear)  r_sig <= '0;
    else if (i_enable) r_sig <= w_sig_next;
  end

  assign o_sig      = r_sig;
  assign o_sig_next = w_sig_next;
endmodule

// File: rtl/exhaustive_stim_sequencer.sv
// Exhaustive stimulus sequencer: walks a combinational DUT through every
// input vector 0 .. 2^IN_W-1, holding each for SETTLE_CYC cycles, and
// compacts the DUT responses into a MISR signature.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   if_seq : slave side of exhaustive_stim_sequencer_if (start/abort, stim,
//            dut_out, busy/done, signature, and golden/pass when enabled)
// Optional feature macro: SIG_COMPARE_EN (golden input, registered pass output).
module exhaustive_stim_sequencer
  import exhaustive_seq_pkg::*;
#(
  parameter int unsigned IN_W       = 6,
  parameter int unsigned OUT_W      = 3,
  parameter int unsigned SIG_W      = 16,
  parameter int unsigned SETTLE_CYC = 1
) (
  input logic                      clk,
  input logic                      rst,
  exhaustive_stim_sequencer_if.slave if_seq
);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_RELOAD = SETTLE_CNT_W'(SETTLE_CYC - 1);

  seq_state_e              r_state;
  logic [IN_W-1:0]         r_stim;
  logic [SETTLE_CNT_W-1:0] r_settle_cnt;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_running;
  logic                    w_abort_run;
  logic                    w_launch;
  logic                    w_capture;
  logic [SIG_W-1:0]        w_sig;
  logic [SIG_W-1:0]        w_sig_next;

  // abort outranks start even in IDLE/DONE, where it otherwise does nothing
  assign w_running   = (r_state == SETTLE) || (r_state == CAPTURE);
  assign w_abort_run = if_seq.abort && w_running;
  assign w_launch    = if_seq.start && !if_seq.abort &&
                       ((r_state == IDLE) || (r_state == DONE));
  assign w_capture   = (r_state == CAPTURE) && !if_seq.abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_stim       <= '0;
      r_settle_cnt <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_launch) begin
            r_state      <= SETTLE;
            r_stim       <= '0;
            r_settle_cnt <= SETTLE_RELOAD;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
          end
        end
        SETTLE: begin
          if (w_abort_run) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_settle_cnt == '0) begin
            r_state <= CAPTURE;
          end else begin
            r_settle_cnt <= r_settle_cnt - SETTLE_CNT_W'(1);
          end
        end
        CAPTURE: begin
          if (w_abort_run) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (&r_stim) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_stim       <= r_stim + IN_W'(1);
            r_settle_cnt <= SETTLE_RELOAD;
            r_state      <= SETTLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sig_misr #(
    .SIG_W  (SIG_W),
    .DATA_W (OUT_W)
  ) u_misr (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_launch),
    .i_enable   (w_capture),
    .i_data     (if_seq.dut_out),
    .o_sig      (w_sig),
    .o_sig_next (w_sig_next)
  );

  assign if_seq.stim      = r_stim;
  assign if_seq.busy      = r_busy;
  assign if_seq.done      = r_done;
  assign if_seq.signature = w_sig;

`ifdef SIG_COMPARE_EN
  logic r_pass;

  // compare against the post-capture value so pass lands together with done
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_pass <= 1'b0;
    else if (w_launch || w_abort_run)       r_pass <= 1'b0;
    else if (w_capture && (&r_stim))        r_pass <= (w_sig_next == if_seq.golden);
  end

  assign if_seq.pass = r_pass;
`else
  logic w_unused_sig_next;
  assign w_unused_sig_next = ^w_sig_next;
`endif
endmodule

// File: tb/tb_exhaustive_stim_sequencer.sv
`timescale 1ns/1ps
module tb_exhaustive_stim_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exhaustive_stim_sequencer_if #(.IN_W(6), .OUT_W(3), .SIG_W(16)) if_a ();
  exhaustive_stim_sequencer_if #(.IN_W(2), .OUT_W(3), .SIG_W(16)) if_b ();
  exhaustive_stim_sequencer_if #(.IN_W(3), .OUT_W(3), .SIG_W(16)) if_c ();

  exhaustive_stim_sequencer #(.IN_W(6), .OUT_W(3), .SIG_W(16), .SETTLE_CYC(1))
    u_dut_a (.clk(clk), .rst(rst), .if_seq(if_a.slave));
  exhaustive_stim_sequencer #(.IN_W(2), .OUT_W(3), .SIG_W(16), .SETTLE_CYC(1))
    u_dut_b (.clk(clk), .rst(rst), .if_seq(if_b.slave));
  exhaustive_stim_sequencer #(.IN_W(3), .OUT_W(3), .SIG_W(16), .SETTLE_CYC(3))
    u_dut_c (.clk(clk), .rst(rst), .if_seq(if_c.slave));

  // combinational DUTs: A is a lookup table, B and C pass stim through
  logic [2:0] lut_a [64];
  always_comb if_a.dut_out = lut_a[if_a.stim];
  always_comb if_b.dut_out = {1'b0, if_b.stim};
  always_comb if_c.dut_out = if_c.stim;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // signature as polynomial arithmetic over GF(2): each step multiplies by x
  // modulo x^16 + P and adds the response word
  function automatic logic [15:0] misr_ref(input int unsigned vals[$]);
    logic [16:0] acc;
    acc = '0;
    foreach (vals[i]) begin
      acc = acc << 1;
      if (acc[16]) acc = acc ^ 17'h11021;
      acc = acc ^ 17'(vals[i]);
    end
    return acc[15:0];
  endfunction

  typedef struct {
    logic [2:0]  lut [64];
    logic [15:0] exp_sig;
    int unsigned exp_cycles;
  } vec_t;

  vec_t vecs [8];

  task automatic run_a(input bit hold, output logic [15:0] sig, output int unsigned cycles,
                       output bit cover_ok, output logic [15:0] sig_e0);
    int unsigned hits [64];
    bit bad;
    foreach (hits[i]) hits[i] = 0;
    bad = 1'b0;
    if_a.start = 1'b1;
    @(posedge clk); #1;
    if (!hold) if_a.start = 1'b0;
    sig_e0 = if_a.signature;
    cycles = 0;
    while (!if_a.done && cycles <= 1000) begin
      if (if_a.busy) hits[if_a.stim]++; else bad = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    if_a.start = 1'b0;
    sig = if_a.signature;
    cover_ok = !bad;
    foreach (hits[i]) if (hits[i] != 2) cover_ok = 1'b0;
  endtask

  task automatic run_b(output logic [15:0] seq, output int unsigned cycles,
                       output logic [15:0] sig, output logic pass_e0);
    seq = '0;
    if_b.start = 1'b1;
    @(posedge clk); #1;
    if_b.start = 1'b0;
`ifdef SIG_COMPARE_EN
    pass_e0 = if_b.pass;
`else
    pass_e0 = 1'b0;
`endif
    cycles = 0;
    while (!if_b.done && cycles <= 200) begin
      seq = {seq[13:0], if_b.stim};
      @(posedge clk); #1;
      cycles++;
    end
    sig = if_b.signature;
  endtask

  task automatic run_c(output int unsigned cycles, output logic [15:0] sig, output bit hold_ok);
    int unsigned hits [8];
    foreach (hits[i]) hits[i] = 0;
    if_c.start = 1'b1;
    @(posedge clk); #1;
    if_c.start = 1'b0;
    cycles = 0;
    while (!if_c.done && cycles <= 200) begin
      hits[if_c.stim]++;
      @(posedge clk); #1;
      cycles++;
    end
    sig = if_c.signature;
    hold_ok = 1'b1;
    foreach (hits[i]) if (hits[i] != 4) hold_ok = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]  sig, sig2, sig_e0, seq, sig_pre;
    int unsigned  cyc;
    bit           cov;
    logic         pass_e0;
    int unsigned  q [$];

    // table of lookup-table DUTs with model-derived expectations
    for (int k = 0; k < 8; k++) begin
      logic [5:0] v;
      q = {};
      for (int i = 0; i < 64; i++) begin
        v = 6'(i);
        case (k)
          0:       vecs[k].lut[i] = 3'd0;
          1:       vecs[k].lut[i] = v[2:0];
          2:       vecs[k].lut[i] = 3'd7;
          3:       vecs[k].lut[i] = v[5:3];
          4:       vecs[k].lut[i] = {2'b00, ^v};
          default: vecs[k].lut[i] = 3'($urandom_range(0, 7));
        endcase
        q.push_back(int'(vecs[k].lut[i]));
      end
      vecs[k].exp_sig    = misr_ref(q);
      vecs[k].exp_cycles = 64 * 2;
    end

    rst = 1'b1;
    if_a.start = 1'b0; if_a.abort = 1'b0;
    if_b.start = 1'b0; if_b.abort = 1'b0;
    if_c.start = 1'b0; if_c.abort = 1'b0;
`ifdef SIG_COMPARE_EN
    if_a.golden = '0; if_b.golden = 16'h0003; if_c.golden = '0;
`endif
    foreach (lut_a[i]) lut_a[i] = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    check("reset_stim", if_a.stim, 0);
    check("reset_busy", if_a.busy, 0);
    check("reset_done", if_a.done, 0);
    check("reset_sig",  if_a.signature, 0);
`ifdef SIG_COMPARE_EN
    check("reset_pass", if_a.pass, 0);
`endif

    for (int k = 0; k < 8; k++) begin
      lut_a = vecs[k].lut;
      run_a(1'b0, sig, cyc, cov, sig_e0);
      check("vec_sig",        sig, vecs[k].exp_sig);
      check("vec_cycles",     cyc, vecs[k].exp_cycles);
      check("vec_cover",      cov, 1);
      check("vec_sig_clear",  sig_e0, 0);
      check("vec_busy_low",   if_a.busy, 0);
      repeat (2) @(posedge clk);
      #1 check("vec_done_hold", if_a.done, 1);
    end

    // re-run from DONE with start held high for the whole run
    foreach (lut_a[i]) lut_a[i] = 3'($urandom_range(0, 7));
    q = {};
    foreach (lut_a[i]) q.push_back(int'(lut_a[i]));
    run_a(1'b0, sig, cyc, cov, sig_e0);
    run_a(1'b1, sig2, cyc, cov, sig_e0);
    check("rerun_same_sig", sig2, sig);
    check("rerun_model",    sig2, misr_ref(q));
    check("held_start_cyc", cyc, 128);
    check("held_start_cov", cov, 1);

    // abort ignored in DONE
    sig_pre = if_a.signature;
    if_a.abort = 1'b1;
    @(posedge clk); #1;
    if_a.abort = 1'b0;
    check("abort_done_keep", if_a.done, 1);
    check("abort_done_sig",  if_a.signature, sig_pre);

    // abort mid-run at cycle 10
    if_a.start = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 sig_pre = if_a.signature;
    if_a.abort = 1'b1;
    @(posedge clk); #1;
    if_a.abort = 1'b0;
    check("abort_busy", if_a.busy, 0);
    check("abort_done", if_a.done, 0);
    check("abort_sig_frozen", if_a.signature, sig_pre);
    repeat (4) @(posedge clk);
    #1;
    check("abort_stay_idle", if_a.busy, 0);
    check("abort_sig_still", if_a.signature, sig_pre);

    // start and abort together in IDLE: abort wins
    if_a.start = 1'b1; if_a.abort = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0; if_a.abort = 1'b0;
    check("start_abort_idle", if_a.busy, 0);
    repeat (3) @(posedge clk);
    #1 check("start_abort_idle2", if_a.busy | if_a.done, 0);

    // reset mid-run at cycle 20
    if_a.start = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid_stim", if_a.stim, 0);
    check("rstmid_busy", if_a.busy, 0);
    check("rstmid_done", if_a.done, 0);
    check("rstmid_sig",  if_a.signature, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("rstmid_idle", if_a.busy | if_a.done, 0);

    // passthrough on the 2-bit DUT
    run_b(seq, cyc, sig, pass_e0);
    check("pt_stim_seq", seq, 16'h05AF);
    check("pt_cycles",   cyc, 8);
    check("pt_sig",      sig, 16'h0003);
`ifdef SIG_COMPARE_EN
    check("pt_pass_good", if_b.pass, 1);
    if_b.golden = 16'h0004;
    run_b(seq, cyc, sig, pass_e0);
    check("pt_pass_clear", pass_e0, 0);
    check("pt_pass_bad",   if_b.pass, 0);
    if_b.golden = 16'h0003;
    run_b(seq, cyc, sig, pass_e0);
    check("pt_pass_again", if_b.pass, 1);
`endif

    // longer settle time on the 3-bit DUT
    run_c(cyc, sig, cov);
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(i);
    check("settle3_cycles", cyc, 32);
    check("settle3_hold",   cov, 1);
    check("settle3_sig",    sig, misr_ref(q));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
